data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Multi-cycle data memory for the RV32IM pipelined CPU, directly downstream of the MA (memory-access) stage.
- Accepts one load or store per transaction and stalls the pipeline via busywait for a fixed latency.
- Performs RISC-V byte, half and word access with little-endian lane alignment, sign/zero extension and store merging.
- Flags misaligned or illegal accesses back to the CPU.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; word index = address[log2(DEPTH_WORDS)+1:2], upper bits ignored (wrap).
- LATENCY, 4, cycles from request acceptance to completion; legal range >= 2.

Ports:
- CLK  input  1  clock; all state changes on rising edge
- RESET  input  1  synchronous, active-high reset
- read  input  1  load request from MA stage
- write  input  1  store request from MA stage
- func3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- address  input  32  byte address
- write_data  input  32  store data (low byte/half used for SB/SH)
- read_data  output  32  load result, valid in DONE cycle only
- busywait  output  1  CPU must hold MA stage while high
- fault  output  1  misaligned/illegal access, valid in DONE cycle only

Behaviour:
- Reset: state=IDLE, counter=0, read_data=0, fault=0, busywait=0; memory array contents are NOT cleared. Reset mid-transaction aborts it with no memory write, and IDLE follows on the next cycle.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - busywait = read|write, combinational, so the CPU stalls in the request cycle.
  - On a request, latch op, func3, address and write_data; counter = LATENCY-2; go to ACCESS.
  - read and write both high: treat as read and ignore write.
- ACCESS:
  - busywait=1; decrement counter.
  - When counter==0, perform the access at this edge, register read_data and fault, then go to DONE.
- DONE:
  - busywait=0; read_data and fault are valid for exactly this cycle.
  - CPU advances at the end of this cycle.
  - Inputs are ignored in DONE. Next state is IDLE, and read_data returns to 0.
- Timing: request in cycle 0, busywait high for cycles 0..LATENCY-1, completion in cycle LATENCY.
- Loads:
  - LB/LBU select byte address[1:0]; LH/LHU select half address[1].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend. LW returns the whole word.
- Stores:
  - SB writes only byte lane address[1:0]; SH writes only half lane address[1]; SW writes all 4 lanes.
  - Unwritten lanes keep their value (read-modify-write of the latched word).
- Fault:
  - Fault conditions: H/HU with address[0]=1; W with address[1:0]!=0; any func3 in {011,110,111}.
  - A faulting store performs no write. A faulting load returns read_data=0.
  - Latency is unchanged on fault.
- Back-to-back: a new request presented in the cycle after DONE is accepted normally, so the minimum spacing between transactions is LATENCY+1 cycles.

Decomposition:
- Shared package holds:
  - func3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding: IDLE, ACCESS, DONE.
  - Memory op encoding.
- One sub-module, mem_lane_align, purely combinational:
  - Load path: byte/half extraction and extension.
  - Store path: byte-enable generation and merge.
  - Fault detection.
- The FSM, counter and memory array stay in data_mem_ctrl.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> busywait high exactly 4 cycles per transaction; read_data=0xDEADBEEF in DONE cycle; fault=0.
- After the above, SB 0x7F @0x11, then LB @0x11, LBU @0x13, LH @0x12 -> word=0xDEAD7FEF; LB returns 0x0000007F; LBU returns 0x000000DE; LH returns 0xFFFFDEAD.
- LW @0x12 and SH @0x11 -> fault=1 in DONE, read_data=0; a subsequent LW @0x10 shows memory unchanged.
- func3=011 read -> fault=1 after LATENCY cycles; FSM returns to IDLE.
- Assert RESET during the 2nd ACCESS cycle of SW 0x12345678 @0x20 -> busywait=0 next cycle; a later LW @0x20 returns the prior contents.
- read=write=1 @0x10 with write_data 0x0 -> executes as load returning the stored value; no write occurs.
- Address 0x410 with DEPTH_WORDS=256 aliases to 0x010 (word index 4).

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// rtl/data_mem_ctrl_pkg.sv - shared constants and types for the data memory controller
package data_mem_ctrl_pkg;

  // RISC-V load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Controller state encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Latched operation kind
  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } mem_op_e;

  // Sign-extend a byte to 32 bits
  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  // Sign-extend a half to 32 bits
  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/data_mem_ctrl_mem_lane_align.sv
// rtl/data_mem_ctrl_mem_lane_align.sv - little-endian lane alignment, extension, store merge and fault detect
module mem_lane_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word,
  output logic [3:0]  byte_en,
  output logic        fault
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] store_rep;

  // Misaligned half/word accesses and reserved funct3 codes are faults
  always_comb begin
    fault = 1'b0;
    case (func3)
      F3_B, F3_BU: fault = 1'b0;
      F3_H, F3_HU: fault = addr_lo[0];
      F3_W:        fault = (addr_lo != 2'b00);
      default:     fault = 1'b1;
    endcase
  end

  // Load path: pick the addressed lane and extend it; faults return zero
  always_comb begin
    byte_sel  = mem_word[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
    load_data = '0;
    case (func3)
      F3_B:    load_data = sext8(byte_sel);
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_H:    load_data = sext16(half_sel);
      F3_HU:   load_data = {16'd0, half_sel};
      F3_W:    load_data = mem_word;
      default: load_data = '0;
    endcase
    if (fault) begin
      load_data = '0;
    end
  end

  // Store path: replicate the low byte/half across lanes and enable only the addressed ones
  always_comb begin
    byte_en   = 4'b0000;
    store_rep = store_data;
    case (func3)
      F3_B, F3_BU: begin
        byte_en   = 4'b0001 << addr_lo;
        store_rep = {4{store_data[7:0]}};
      end
      F3_H, F3_HU: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_rep = {2{store_data[15:0]}};
      end
      F3_W: begin
        byte_en   = 4'b1111;
        store_rep = store_data;
      end
      default: begin
        byte_en   = 4'b0000;
        store_rep = store_data;
      end
    endcase
    if (fault) begin
      byte_en = 4'b0000;
    end
  end

  // Read-modify-write merge: untouched lanes keep the current word's bytes
  always_comb begin
    merged_word = mem_word;
    for (int i = 0; i < 4; i++) begin
      merged_word[8*i +: 8] = byte_en[i] ? store_rep[8*i +: 8] : mem_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - multi-cycle RV32 data memory with busywait stall and fault reporting
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        read,
  input  logic        write,
  input  logic [2:0]  func3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        busywait,
  output logic        fault
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 2);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  counter_q, counter_d;
  mem_op_e           op_q, op_d;
  logic [2:0]        func3_q, func3_d;
  logic [IDX_W+1:0]  addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       read_data_q, read_data_d;
  logic              fault_q, fault_d;

  logic              mem_we;
  logic [IDX_W-1:0]  word_idx;
  logic [31:0]       mem_word;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;
  logic [3:0]        byte_en;
  logic              align_fault;
  logic              unused_addr;

  logic [31:0] mem [DEPTH_WORDS];

  // Upper address bits beyond the array simply wrap
  assign unused_addr = ^address[31:IDX_W+2];

  assign word_idx = addr_q[IDX_W+1:2];
  assign mem_word = mem[word_idx];

  mem_lane_align u_align (
    .func3       (func3_q),
    .addr_lo     (addr_q[1:0]),
    .mem_word    (mem_word),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word),
    .byte_en     (byte_en),
    .fault       (align_fault)
  );

  // Stall in the request cycle itself so the CPU never runs ahead of acceptance
  assign busywait  = (state_q == IDLE) ? (read | write) : (state_q == ACCESS);
  assign read_data = read_data_q;
  assign fault     = fault_q;

  // Next-state logic: latch request, count down latency, complete access
  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    op_d        = op_q;
    func3_d     = func3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    read_data_d = '0;
    fault_d     = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (read | write) begin
          // A simultaneous read and write resolves to a load
          op_d      = read ? OP_LOAD : OP_STORE;
          func3_d   = func3;
          addr_d    = address[IDX_W+1:0];
          wdata_d   = write_data;
          counter_d = CNT_INIT;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (counter_q == '0) begin
          fault_d     = align_fault;
          read_data_d = (op_q == OP_LOAD) ? load_data : '0;
          mem_we      = (op_q == OP_STORE) && !align_fault;
          state_d     = DONE;
        end else begin
          counter_d = counter_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state and registered outputs; reset aborts any transaction in flight
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      op_q        <= OP_LOAD;
      func3_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      op_q        <= op_d;
      func3_q     <= func3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      fault_q     <= fault_d;
    end
  end

  // Memory array write; contents survive reset
  always_ff @(posedge CLK) begin
    if (mem_we && !RESET) begin
      mem[word_idx] <= merged_word;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;

  logic        CLK;
  logic        RESET;
  logic        read;
  logic        write;
  logic [2:0]  func3;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        busywait;
  logic        fault;

  int checks;
  int errors;

  logic [31:0] t_rdata;
  logic        t_fault;
  int          t_busy;

  data_mem_ctrl #(
    .DEPTH_WORDS (256),
    .LATENCY     (4)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .read       (read),
    .write      (write),
    .func3      (func3),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .busywait   (busywait),
    .fault      (fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd);
    int n;
    @(posedge CLK); #1;
    read = rd; write = wr; func3 = f3; address = addr; write_data = wd;
    #1;
    t_busy = 0;
    n = 0;
    while (busywait && n < 50) begin
      t_busy++;
      @(posedge CLK); #1;
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL txn_timeout: busywait still %0b after %0d cycles, required 0", busywait, n);
    end
    t_rdata = read_data;
    t_fault = fault;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; read = 1'b0; write = 1'b0; func3 = 3'b000; address = '0; write_data = '0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (busywait !== 1'b0) begin errors++; $display("FAIL reset_busywait: got %0b want 0", busywait); end
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data: got %h want 00000000", read_data); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %0b want 0", fault); end
    RESET = 1'b0;
  endtask

  task automatic test_word();
    txn(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    checks++; if (t_busy !== 4) begin errors++; $display("FAIL sw_busy: got %0d want 4", t_busy); end
    checks++; if (t_fault !== 1'b0) begin errors++; $display("FAIL sw_fault: got %0b want 0", t_fault); end
    txn(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    checks++; if (t_busy !== 4) begin errors++; $display("FAIL lw_busy: got %0d want 4", t_busy); end
    checks++; if (t_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", t_rdata); end
    checks++; if (t_fault !== 1'b0) begin errors++; $display("FAIL lw_fault: got %0b want 0", t_fault); end
    @(posedge CLK); #1;
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL lw_data_after_done: got %h want 00000000", read_data); end
  endtask

  task automatic test_byte_half();
    txn(1'b0, 1'b1, 3'b000, 32'h11, 32'hAAAAAA7F);
    checks++; if (t_fault !== 1'b0) begin errors++; $display("FAIL sb_fault: got %0b want 0", t_fault); end
    txn(1'b1, 1'b0, 3'b000, 32'h11, 32'h0);
    checks++; if (t_rdata !== 32'h0000007F) begin errors++; $display("FAIL lb_11: got %h want 0000007f", t_rdata); end
    txn(1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
    checks++; if (t_rdata !== 32'h000000DE) begin errors++; $display("FAIL lbu_13: got %h want 000000de", t_rdata); end
    txn(1'b1, 1'b0, 3'b001, 32'h12, 32'h0);
    checks++; if (t_rdata !== 32'hFFFFDEAD) begin errors++; $display("FAIL lh_12: got %h want ffffdead", t_rdata); end
    txn(1'b1, 1'b0, 3'b101, 32'h12, 32'h0);
    checks++; if (t_rdata !== 32'h0000DEAD) begin errors++; $display("FAIL lhu_12: got %h want 0000dead", t_rdata); end
    txn(1'b1, 1'b0, 3'b000, 32'h10, 32'h0);
    checks++; if (t_rdata !== 32'hFFFFFFEF) begin errors++; $display("FAIL lb_10: got %h want ffffffef", t_rdata); end
    txn(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    checks++; if (t_rdata !== 32'hDEAD7FEF) begin errors++; $display("FAIL lw_after_sb: got %h want dead7fef", t_rdata); end
  endtask

  task automatic test_fault();
    txn(1'b1, 1'b0, 3'b010, 32'h12, 32'h0);
    checks++; if (t_fault !== 1'b1) begin errors++; $display("FAIL lw_mis_fault: got %0b want 1", t_fault); end
    checks++; if (t_rdata !== 32'h0) begin errors++; $display("FAIL lw_mis_data: got %h want 00000000", t_rdata); end
    checks++; if (t_busy !== 4) begin errors++; $display("FAIL lw_mis_busy: got %0d want 4", t_busy); end
    txn(1'b0, 1'b1, 3'b001, 32'h11, 32'h0000FFFF);
    checks++; if (t_fault !== 1'b1) begin errors++; $display("FAIL sh_mis_fault: got %0b want 1", t_fault); end
    checks++; if (t_rdata !== 32'h0) begin errors++; $display("FAIL sh_mis_data: got %h want 00000000", t_rdata); end
    txn(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    checks++; if (t_rdata !== 32'hDEAD7FEF) begin errors++; $display("FAIL lw_after_fault: got %h want dead7fef", t_rdata); end
  endtask

  task automatic test_illegal();
    txn(1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
    checks++; if (t_fault !== 1'b1) begin errors++; $display("FAIL f3_011_fault: got %0b want 1", t_fault); end
    checks++; if (t_busy !== 4) begin errors++; $display("FAIL f3_011_busy: got %0d want 4", t_busy); end
    checks++; if (t_rdata !== 32'h0) begin errors++; $display("FAIL f3_011_data: got %h want 00000000", t_rdata); end
    @(posedge CLK); #1;
    checks++; if (busywait !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL f3_011_idle: busywait %0b fault %0b want 0 0", busywait, fault); end
  endtask

  task automatic test_reset_abort();
    txn(1'b0, 1'b1, 3'b010, 32'h20, 32'h0BADF00D);
    @(posedge CLK); #1;
    write = 1'b1; func3 = 3'b010; address = 32'h20; write_data = 32'h12345678;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b1; write = 1'b0;
    @(posedge CLK); #1;
    checks++; if (busywait !== 1'b0) begin errors++; $display("FAIL abort_busywait: got %0b want 0", busywait); end
    RESET = 1'b0;
    txn(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    checks++; if (t_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL abort_mem: got %h want 0badf00d", t_rdata); end
  endtask

  task automatic test_read_write();
    txn(1'b1, 1'b1, 3'b010, 32'h10, 32'h00000000);
    checks++; if (t_rdata !== 32'hDEAD7FEF) begin errors++; $display("FAIL rw_load: got %h want dead7fef", t_rdata); end
    txn(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    checks++; if (t_rdata !== 32'hDEAD7FEF) begin errors++; $display("FAIL rw_nowrite: got %h want dead7fef", t_rdata); end
  endtask

  task automatic test_alias();
    txn(1'b1, 1'b0, 3'b010, 32'h410, 32'h0);
    checks++; if (t_rdata !== 32'hDEAD7FEF) begin errors++; $display("FAIL alias_load: got %h want dead7fef", t_rdata); end
    txn(1'b0, 1'b1, 3'b010, 32'h410, 32'hCAFEF00D);
    txn(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    checks++; if (t_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL alias_store: got %h want cafef00d", t_rdata); end
  endtask

  task automatic test_sh_merge();
    txn(1'b0, 1'b1, 3'b001, 32'h12, 32'hFFFF1234);
    checks++; if (t_fault !== 1'b0) begin errors++; $display("FAIL sh_fault: got %0b want 0", t_fault); end
    txn(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    checks++; if (t_rdata !== 32'h1234F00D) begin errors++; $display("FAIL sh_merge: got %h want 1234f00d", t_rdata); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_word();
    test_byte_half();
    test_fault();
    test_illegal();
    test_reset_abort();
    test_read_write();
    test_alias();
    test_sh_merge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
